// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader.
// Checksum support is enabled with BOOT_LOADER_CHECKSUM_EN.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_LOAD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// word_valid_o pulses combinationally with the 4th byte of each word.
module word_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;

  always_comb begin
    idx_d = idx_q;
    buf_d = buf_q;
    if (clr_i) begin
      idx_d = '0;
      buf_d = '0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_q)
        2'd0: buf_d[7:0]   = byte_i;
        2'd1: buf_d[15:8]  = byte_i;
        2'd2: buf_d[23:16] = byte_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  assign word_valid_o = byte_valid_i && (idx_q == LAST);
  assign word_o       = {byte_i, buf_q};

endmodule

// File: rtl/boot_loader.sv
// Streams a program image into instruction memory, holding the core in reset.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CSUM;
`else
  localparam state_e S_END = S_DONE;
`endif

  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic        asm_clr;
  logic        asm_vld;
  logic [31:0] asm_word;
  logic        asm_wvld;
  logic [15:0] n_hdr;

  assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign accept   = in_valid && in_ready;
  assign asm_clr  = accept && (state_q == S_HDR1);
  assign asm_vld  = accept && (state_q == S_LOAD);
  assign n_hdr    = {in_data, n_q[7:0]};

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (asm_clr),
    .byte_valid_i (asm_vld),
    .byte_i       (in_data),
    .word_o       (asm_word),
    .word_valid_o (asm_wvld)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_HDR0: begin
        if (accept) begin
          n_d     = {n_q[15:8], in_data};
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          n_d   = n_hdr;
          cnt_d = '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum_d = '0;
`endif
          if ({1'b0, n_hdr} > MAXW)
            state_d = S_ERR;
          else if (n_hdr == 16'd0)
            state_d = S_END;
          else
            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (asm_wvld) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = asm_word;
            cnt_d   = cnt_q + 16'd1;
            if (cnt_q + 16'd1 == n_q)
              state_d = S_END;
          end
        end
      end
      S_CSUM: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (accept)
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
`else
        state_d = S_ERR;
`endif
      end
      S_DONE: ;
      S_ERR:  ;
      default: state_d = S_HDR0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HDR0;
      n_q     <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  // Final strobe may overlap DONE entry; release the core only after it.
  assign done       = (state_q == S_DONE) && !we_q;
  assign core_rst_n = done;
  assign error      = (state_q == S_ERR);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: doc/boot_loader.md
# boot_loader

Loads a program image into the core's instruction memory before execution. It accepts a byte stream over a valid/ready handshake, typically from a UART receiver, and assembles little-endian 32-bit words. Each word is written through the instruction memory's write port at consecutive word addresses. The single-cycle core is held in reset until the whole image has been written, and is then released.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, largest accepted image in words; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  byte present on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- core_rst_n  out  1  active-low reset to the core; low while loading.
- done  out  1  image loaded; sticky until rst.
- error  out  1  load failed; sticky until rst.

## Operation
- A byte is accepted on a cycle with in_valid && in_ready. Bytes are never accepted otherwise.
- Image format: 2-byte word count N (little-endian), then 4·N payload bytes (each word little-endian). With CHECKSUM_EN, a trailing 1-byte checksum follows the payload.
- FSM states:
  - HDR0: accept N[7:0], then go to HDR1.
  - HDR1: accept N[15:8], then:
    - N > MAX_WORDS → ERR.
    - N == 0 → CSUM if checksum is compiled in, else DONE.
    - otherwise → LOAD.
  - LOAD: shift bytes into a 32-bit word; byte k lands in bits [8k+7:8k].
    - On the 4th byte: register the word and address, and pulse imem_we on the next cycle.
    - The word counter increments from 0.
    - When the counter reaches N, go to CSUM (checksum compiled in) or DONE.
  - CSUM: accept one byte. It must equal the running XOR of all payload bytes (headers excluded): match → DONE, mismatch → ERR.
  - DONE / ERR: terminal states; only rst leaves them.
- in_ready = 1 in HDR0, HDR1, LOAD and CSUM; 0 in DONE and ERR. The loader never back-pressures mid-image.
- imem_addr equals the word index (0, 1, … N−1). Addresses do not wrap because N ≤ MAX_WORDS ≤ 2^ADDR_W.
- core_rst_n = 1 only in DONE.
- Reset values: state HDR0, in_ready 1, imem_we 0, imem_addr 0, imem_wdata 0, core_rst_n 0, done 0, error 0, counters and checksum 0.
- Reset mid-load: all state is cleared and the next byte is treated as N[7:0]. Partially written memory contents are left as-is.

## Timing
- imem_we is high for exactly one cycle, in the cycle after the 4th byte of a word is accepted. imem_addr and imem_wdata are valid in that same cycle.
- Back-to-back bytes on every cycle are supported, giving a maximum of one write every 4 cycles.
- After the last write strobe, or after the checksum byte is accepted, the FSM enters DONE on the next edge. done and core_rst_n rise in that same cycle, never before the final write strobe has completed.
- ERR: error rises the cycle after the offending byte is accepted. core_rst_n stays 0.
- Reset assertion takes effect immediately (asynchronous). After release, the first byte is accepted on the first edge where in_valid = 1.

## Configuration
- BOOT_LOADER_CHECKSUM_EN defined: the CSUM state and XOR accumulator are compiled in. The image carries a trailing checksum byte, and a mismatch leads to ERR.
- Not defined: no CSUM state. The last payload byte (or HDR1 when N = 0) leads directly to DONE. error can then only come from N > MAX_WORDS.

## Structure
- A shared package holds:
  - the FSM state enum (HDR0, HDR1, LOAD, CSUM, DONE, ERR);
  - the header length constant (2 bytes);
  - the bytes-per-word constant (4).
- One sub-module, word_assembler: takes bytes with a byte-valid strobe and outputs a 32-bit word with a word-valid pulse on the 4th byte. It is cleared by the FSM at the start of each image.

## Test plan
- N = 2, payload 78 56 34 12 EF BE AD DE (no checksum) → write 0x12345678 @0, then 0xDEADBEEF @1. done = 1 and core_rst_n = 1 one cycle after the 2nd strobe.
- N = 3 with in_valid toggling every other cycle → 3 correct writes @0..2, no duplicated or dropped bytes, in_ready high throughout.
- N = 0x0401 with MAX_WORDS = 1024 → error = 1 one cycle after HDR1, no imem_we, core_rst_n = 0, in_ready = 0.
- CHECKSUM_EN, N = 1, payload 01 02 04 08: checksum 0x0F → done; checksum 0x0E → error, core_rst_n stays 0.
- rst asserted after 5 payload bytes, then a fresh N = 1 image → single write @0 with the new word; no strobe from the aborted image after rst.
- After done, further in_valid bytes → in_ready = 0, no writes, outputs unchanged.
